mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter MEM_LAT, default 2, memory read/write latency in cycles (legal 1..15).
REQ-003 Parameter STARVE_MAX, default 4, maximum consecutive DM grants while IF waits.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch request, held until if_done.
REQ-007 if_addr  in  ADDR_W  fetch byte address.
REQ-008 if_done  out  1  one-cycle fetch completion pulse.
REQ-009 if_rdata  out  32  fetched instruction.
REQ-010 if_stall  out  1  fetch pending, not complete.
REQ-011 dm_req  in  1  data-memory request, held until dm_done.
REQ-012 dm_addr  in  ADDR_W  data byte address.
REQ-013 dm_w_mask  in  8  byte write mask; 8'h00 means read.
REQ-014 dm_wdata  in  64  store data.
REQ-015 dm_done  out  1  one-cycle data completion pulse.
REQ-016 dm_rdata  out  64  load data.
REQ-017 dm_stall  out  1  data access pending, not complete.
REQ-018 mem_en  out  1  one-cycle access strobe to the shared memory.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_w_mask  out  8  memory byte write mask.
REQ-021 mem_wdata  out  64  memory write data.
REQ-022 mem_rdata  in  64  memory read data, valid MEM_LAT cycles after mem_en.
REQ-023 busy  out  1  transaction in flight.

Function
REQ-024 FSM states: IDLE, WAIT; at most one transaction outstanding.
REQ-025 In IDLE, if any request is pending, grant one: mem_en=1 that cycle, move to WAIT, load the latency counter with MEM_LAT.
REQ-026 Latch owner, addr, mask and wdata at grant; mem_addr/mem_w_mask/mem_wdata come from the granted request in the grant cycle.
REQ-027 IF grant drives mem_w_mask=8'h00; DM grant drives mem_w_mask=dm_w_mask.
REQ-028 mem_w_mask=8'h00 whenever mem_en=0.
REQ-029 Priority: DM over IF, except IF wins when starve_cnt==STARVE_MAX and both request.
REQ-030 starve_cnt increments (saturating at STARVE_MAX) on each DM grant while if_req=1, and clears on IF grant or when if_req=0 in IDLE.
REQ-031 Grant at cycle T gives the owner's done=1 at cycle T+MEM_LAT, with rdata taken combinationally from mem_rdata; the FSM returns to IDLE at the next edge, and the earliest next grant is T+MEM_LAT+1.
REQ-032 Writes also complete with done at T+MEM_LAT; dm_rdata is don't-care for writes.
REQ-033 if_rdata = mem_rdata[63:32] when latched addr[2]=1, else mem_rdata[31:0].
REQ-034 if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done; busy=1 in WAIT.
REQ-035 If a request is withdrawn mid-transaction, the transaction still completes and done still pulses exactly once.
REQ-036 A request held high across its done cycle is not re-granted in that cycle; it may be re-granted in IDLE next cycle.

Reset
REQ-037 rst=0 at a clock edge forces IDLE, counter=0, starve_cnt=0 and latched fields=0.
REQ-038 While reset is asserted: mem_en, mem_w_mask, mem_addr, mem_wdata, if_done, dm_done and busy are 0; if_rdata/dm_rdata are 0.
REQ-039 Reset mid-transaction aborts it: no done pulse, and a late mem_rdata is ignored.

Verification
REQ-040 Reset asserted 2 cycles, no requests -> all outputs 0, busy=0.
REQ-041 IF alone, if_addr=0x104, mem_rdata=0xAAAABBBB_CCCCDDDD at T+2 -> mem_en at T with mask 0, if_done at T+2, if_rdata=0xAAAABBBB, if_stall 1 for T..T+1.
REQ-042 IF and DM store (mask 0x0F, wdata 0x11223344) in the same cycle T -> DM granted at T with mem_w_mask=0x0F, dm_done at T+2, IF granted at T+3, if_done at T+5.
REQ-043 dm_req and if_req held high continuously -> grants DM,DM,DM,DM,IF, then DM again; starve_cnt cleared after the IF grant.
REQ-044 DM load granted at T, rst=0 at T+1 -> no dm_done, busy=0 at T+2, and a new grant occurs in the first cycle with rst=1.
REQ-045 if_req dropped at T+1 after grant at T -> exactly one if_done at T+2, no mem_en at T+3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory between fetch and data.
// Data has priority; fetch wins once data has starved it for STARVE_MAX grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [7:0]        dm_w_mask,
  input  logic [63:0]       dm_wdata,
  output logic              dm_done,
  output logic [63:0]       dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_w_mask,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [SW-1:0]     r_starve;
  logic [SW-1:0]     w_starve_nxt;
  logic              r_own_dm;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mask;
  logic [63:0]       r_wdata;

  logic w_idle;
  logic w_starved;
  logic w_gnt_if;
  logic w_gnt_dm;
  logic w_gnt;
  logic w_last;
  logic w_done;
  logic w_unused_mask;

  // Grants are suppressed while reset is held low.
  assign w_idle    = (r_state == S_IDLE);
  assign w_starved = (r_starve == SW'(STARVE_MAX));
  assign w_gnt_if  = rst & w_idle & if_req & (~dm_req | w_starved);
  assign w_gnt_dm  = rst & w_idle & dm_req & ~w_gnt_if;
  assign w_gnt     = w_gnt_if | w_gnt_dm;
  assign w_last    = (r_state == S_WAIT) && (r_cnt == 4'd1);
  assign w_done    = rst & w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'(MEM_LAT);
        end
      end
      S_WAIT: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_idle) begin
      if (w_gnt_if || !if_req) begin
        w_starve_nxt = '0;
      end else if (w_gnt_dm && !w_starved) begin
        w_starve_nxt = r_starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_starve <= '0;
      r_own_dm <= 1'b0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
      if (w_gnt) begin
        r_own_dm <= w_gnt_dm;
        r_addr   <= w_gnt_dm ? dm_addr : if_addr;
        r_mask   <= w_gnt_dm ? dm_w_mask : 8'h00;
        r_wdata  <= w_gnt_dm ? dm_wdata : 64'd0;
      end
    end
  end

  assign w_unused_mask = ^r_mask;

  assign mem_en     = w_gnt;
  assign mem_w_mask = w_gnt_dm ? dm_w_mask : 8'h00;
  assign mem_addr   = !rst     ? '0 :
                      w_gnt_dm ? dm_addr :
                      w_gnt_if ? if_addr : r_addr;
  assign mem_wdata  = !rst     ? 64'd0 :
                      w_gnt_dm ? dm_wdata : r_wdata;

  assign if_done  = w_done & ~r_own_dm;
  assign dm_done  = w_done & r_own_dm;
  assign if_rdata = !rst      ? 32'd0 :
                    r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign dm_rdata = rst ? mem_rdata : 64'd0;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign busy     = rst & (r_state == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default parameters.
// Cycles are observed #1 after each rising edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [7:0]  dm_w_mask;
  logic [63:0] dm_wdata;
  logic        dm_done;
  logic [63:0] dm_rdata;
  logic        dm_stall;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_w_mask;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_w_mask (dm_w_mask),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .dm_stall  (dm_stall),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_w_mask(mem_w_mask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_addr = '0;
    dm_w_mask = '0; dm_wdata = '0;
    mem_rdata = 64'hFFFF_0000_1234_5678;
    step();
    step();
    n_tot++;
    if ({mem_en, mem_w_mask, mem_addr, mem_wdata} !== '0)
      $display("FAIL rst_mem got en=%b m=%h a=%h d=%h exp 0",
               mem_en, mem_w_mask, mem_addr, mem_wdata);
    else n_pass++;
    n_tot++;
    if ({if_done, dm_done, busy} !== 3'b000)
      $display("FAIL rst_flags got %b exp 000", {if_done, dm_done, busy});
    else n_pass++;
    n_tot++;
    if ({if_rdata, dm_rdata} !== 96'd0)
      $display("FAIL rst_rdata got %h %h exp 0", if_rdata, dm_rdata);
    else n_pass++;
    mem_rdata = '0;
    rst = 1'b1;
    step();
    n_tot++;
    if ({mem_en, busy} !== 2'b00)
      $display("FAIL post_rst got %b exp 00", {mem_en, busy});
    else n_pass++;
  endtask

  task automatic test_if_alone();
    if_req = 1'b1; if_addr = 32'h104;
    #1;
    n_tot++;
    if ({mem_en, mem_w_mask, mem_addr, busy, if_stall} !== {1'b1, 8'h00, 32'h104, 1'b0, 1'b1})
      $display("FAIL if_grant got en=%b m=%h a=%h b=%b s=%b exp 1 00 104 0 1",
               mem_en, mem_w_mask, mem_addr, busy, if_stall);
    else n_pass++;
    step();
    n_tot++;
    if ({mem_en, busy, if_stall, if_done} !== 4'b0110)
      $display("FAIL if_wait got %b exp 0110", {mem_en, busy, if_stall, if_done});
    else n_pass++;
    step();
    mem_rdata = 64'hAAAABBBB_CCCCDDDD;
    #1;
    n_tot++;
    if ({if_done, if_stall, dm_done} !== 3'b100)
      $display("FAIL if_done got %b exp 100", {if_done, if_stall, dm_done});
    else n_pass++;
    n_tot++;
    if (if_rdata !== 32'hAAAABBBB)
      $display("FAIL if_rdata_hi got %h exp aaaabbbb", if_rdata);
    else n_pass++;
    n_tot++;
    if (mem_en !== 1'b0)
      $display("FAIL if_no_regrant got %b exp 0", mem_en);
    else n_pass++;
    step();
    if_req = 1'b0; mem_rdata = '0;
    #1;
    n_tot++;
    if ({mem_en, busy, if_done} !== 3'b000)
      $display("FAIL if_after got %b exp 000", {mem_en, busy, if_done});
    else n_pass++;
  endtask

  task automatic test_contend();
    step();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_addr = 32'h300;
    dm_w_mask = 8'h0F; dm_wdata = 64'h11223344;
    #1;
    n_tot++;
    if ({mem_en, mem_w_mask, mem_addr, mem_wdata} !== {1'b1, 8'h0F, 32'h300, 64'h11223344})
      $display("FAIL dm_wr_grant got en=%b m=%h a=%h d=%h exp 1 0f 300 11223344",
               mem_en, mem_w_mask, mem_addr, mem_wdata);
    else n_pass++;
    step();
    step();
    n_tot++;
    if ({dm_done, if_done, dm_stall, if_stall} !== 4'b1001)
      $display("FAIL dm_wr_done got %b exp 1001", {dm_done, if_done, dm_stall, if_stall});
    else n_pass++;
    step();
    dm_req = 1'b0; dm_w_mask = '0;
    #1;
    n_tot++;
    if ({mem_en, mem_w_mask, mem_addr} !== {1'b1, 8'h00, 32'h200})
      $display("FAIL if_second got en=%b m=%h a=%h exp 1 00 200",
               mem_en, mem_w_mask, mem_addr);
    else n_pass++;
    step();
    step();
    mem_rdata = 64'h01234567_89ABCDEF;
    #1;
    n_tot++;
    if ({if_done, if_rdata} !== {1'b1, 32'h89ABCDEF})
      $display("FAIL if_second_done got %b %h exp 1 89abcdef", if_done, if_rdata);
    else n_pass++;
    step();
    if_req = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_starve();
    logic [5:0] exp_dm;
    exp_dm = 6'b101111;
    step();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_addr = 32'h80;
    #1;
    for (int g = 0; g < 6; g++) begin
      n_tot++;
      if ({mem_en, mem_addr} !== {1'b1, (exp_dm[g] ? 32'h80 : 32'h40)})
        $display("FAIL starve_grant%0d got en=%b a=%h exp dm=%b",
                 g, mem_en, mem_addr, exp_dm[g]);
      else n_pass++;
      step();
      step();
      n_tot++;
      if ({dm_done, if_done, mem_en} !== {exp_dm[g], ~exp_dm[g], 1'b0})
        $display("FAIL starve_done%0d got %b exp dm=%b no_en",
                 g, {dm_done, if_done, mem_en}, exp_dm[g]);
      else n_pass++;
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    #1;
    n_tot++;
    if (mem_en !== 1'b0)
      $display("FAIL starve_drop got %b exp 0", mem_en);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    step();
    dm_req = 1'b1; dm_addr = 32'h500; dm_w_mask = 8'h00;
    #1;
    n_tot++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h500})
      $display("FAIL abort_grant got en=%b a=%h exp 1 500", mem_en, mem_addr);
    else n_pass++;
    step();
    rst = 1'b0;
    #1;
    n_tot++;
    if ({mem_en, busy, dm_done} !== 3'b000)
      $display("FAIL abort_in_rst got %b exp 000", {mem_en, busy, dm_done});
    else n_pass++;
    step();
    rst = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    n_tot++;
    if ({busy, dm_done, mem_en} !== 3'b001)
      $display("FAIL abort_regrant got %b exp 001", {busy, dm_done, mem_en});
    else n_pass++;
    step();
    mem_rdata = 64'h5555_6666_7777_8888;
    step();
    n_tot++;
    if ({dm_done, dm_rdata} !== {1'b1, 64'h5555_6666_7777_8888})
      $display("FAIL abort_newdone got %b %h exp 1 5555666677778888", dm_done, dm_rdata);
    else n_pass++;
    step();
    dm_req = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_withdraw();
    step();
    if_req = 1'b1; if_addr = 32'h10C;
    #1;
    n_tot++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h10C})
      $display("FAIL wd_grant got en=%b a=%h exp 1 10c", mem_en, mem_addr);
    else n_pass++;
    step();
    if_req = 1'b0;
    #1;
    n_tot++;
    if ({if_done, if_stall, busy} !== 3'b001)
      $display("FAIL wd_mid got %b exp 001", {if_done, if_stall, busy});
    else n_pass++;
    step();
    mem_rdata = 64'h0F0F0F0F_12121212;
    #1;
    n_tot++;
    if ({if_done, if_rdata} !== {1'b1, 32'h0F0F0F0F})
      $display("FAIL wd_done got %b %h exp 1 0f0f0f0f", if_done, if_rdata);
    else n_pass++;
    step();
    n_tot++;
    if ({mem_en, if_done, busy} !== 3'b000)
      $display("FAIL wd_after got %b exp 000", {mem_en, if_done, busy});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_if_alone();
    test_contend();
    test_starve();
    test_reset_abort();
    test_withdraw();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
